// File: rtl/bus_sram_target.sv
`default_nettype none
// ============================================================================
// Module   : bus_sram_target
// Purpose  : Word-addressed on-chip SRAM slave on the shared system bus.
//            Serves single and burst reads/writes issued by the JTAG DMA
//            master. All bus outputs are zero whenever this target is not
//            responding so they can be OR-combined with other targets.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock               in   1  system clock, rising edge
//   n_reset             in   1  asynchronous active-low reset
//   address_dataIN      in  32  address on begin cycle, write data on beats
//   byte_enableIN       in   4  byte lanes, latched for the whole burst
//   burst_sizeIN        in   8  beats minus one
//   read_n_writeIN      in   1  1 = read, 0 = write
//   begin_transactionIN in   1  one-cycle transaction start
//   end_transactionIN   in   1  master ends a write / aborts a read
//   data_validIN        in   1  write beat valid
//   busyIN              in   1  master cannot take a read beat this cycle
//   address_dataOUT     out 32  read data, zero when not valid
//   data_validOUT       out  1  read beat valid
//   end_transactionOUT  out  1  one-cycle end of read or error response
//   busyOUT             out  1  write stall (never asserted)
//   errorOUT            out  1  one-cycle error with end_transactionOUT
// ============================================================================
module bus_sram_target #(
  parameter logic [31:0] BASE_ADDRESS = 32'h4000_0000,
  parameter int unsigned ADDR_WIDTH   = 9
) (
  input  logic        clock,
  input  logic        n_reset,
  input  logic [31:0] address_dataIN,
  input  logic [3:0]  byte_enableIN,
  input  logic [7:0]  burst_sizeIN,
  input  logic        read_n_writeIN,
  input  logic        begin_transactionIN,
  input  logic        end_transactionIN,
  input  logic        data_validIN,
  input  logic        busyIN,
  output logic [31:0] address_dataOUT,
  output logic        data_validOUT,
  output logic        end_transactionOUT,
  output logic        busyOUT,
  output logic        errorOUT
);

  localparam int unsigned DEPTH       = 2 ** ADDR_WIDTH;
  localparam logic [31:0] c_LAST_WORD = 32'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_RFETCH = 3'd2,
    S_READ   = 3'd3,
    S_RDONE  = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [8:0]              r_count;
  logic [3:0]              r_be;
  logic [31:0]             r_rdata;
  logic [31:0]             r_mem [0:DEPTH-1];

  logic                    w_sel;
  logic [ADDR_WIDTH-1:0]   w_begin_word;
  logic [31:0]             w_last_word;
  logic                    w_range_err;
  logic                    w_wr_beat;
  logic                    w_rd_accept;
  logic                    w_rd_en;
  logic [ADDR_WIDTH-1:0]   w_addr_inc;
  logic [ADDR_WIDTH-1:0]   w_rd_addr;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  assign w_sel        = (r_state == S_IDLE) && begin_transactionIN &&
                        (address_dataIN[31:ADDR_WIDTH+2] ==
                         BASE_ADDRESS[31:ADDR_WIDTH+2]);
  assign w_begin_word = address_dataIN[ADDR_WIDTH+1:2];
  // Last word touched by the burst; beyond the window means an error reply.
  assign w_last_word  = 32'(w_begin_word) + 32'(burst_sizeIN);
  assign w_range_err  = (w_last_word > c_LAST_WORD);

  // Beats past the latched length are dropped once the counter hits zero.
  assign w_wr_beat    = (r_state == S_WRITE) && data_validIN && (r_count != 9'd0);
  // An abort takes priority over accepting the presented beat.
  assign w_rd_accept  = (r_state == S_READ) && !busyIN && !end_transactionIN;

  assign w_addr_inc   = r_addr + ADDR_WIDTH'(1);

  // The SRAM is fetched one word ahead: during RFETCH the first word, and on
  // every accepted beat the following word, so beats stream at 1 word/cycle.
  // While stalled the read port is idle and r_rdata holds the current word.
  assign w_rd_en      = (r_state == S_RFETCH) || w_rd_accept;
  assign w_rd_addr    = w_rd_accept ? w_addr_inc : r_addr;

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_sel) begin
          if (w_range_err) begin
            w_next_state = S_ERR;
          end else if (read_n_writeIN) begin
            w_next_state = S_RFETCH;
          end else begin
            w_next_state = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (end_transactionIN) begin
          w_next_state = S_IDLE;
        end
      end
      S_RFETCH: begin
        w_next_state = S_READ;
      end
      S_READ: begin
        if (end_transactionIN) begin
          w_next_state = S_IDLE;
        end else if (!busyIN && (r_count == 9'd1)) begin
          w_next_state = S_RDONE;
        end
      end
      S_RDONE: begin
        w_next_state = S_IDLE;
      end
      S_ERR: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Address / beat counter / byte-enable latch
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_addr  <= '0;
      r_count <= 9'd0;
      r_be    <= 4'd0;
    end else begin
      if (w_sel) begin
        r_addr  <= w_begin_word;
        r_count <= {1'b0, burst_sizeIN} + 9'd1;
        r_be    <= byte_enableIN;
      end else if (w_wr_beat || w_rd_accept) begin
        r_addr  <= w_addr_inc;
        r_count <= r_count - 9'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // SRAM array: no reset, contents survive n_reset
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (w_wr_beat) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) begin
          r_mem[r_addr][8*b +: 8] <= address_dataIN[8*b +: 8];
        end
      end
    end
    if (w_rd_en) begin
      r_rdata <= r_mem[w_rd_addr];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs decoded from registered state; zero whenever not responding and
  // forced low immediately by the asynchronous reset of r_state.
  // --------------------------------------------------------------------------
  assign data_validOUT      = (r_state == S_READ);
  assign address_dataOUT    = data_validOUT ? r_rdata : 32'd0;
  assign end_transactionOUT = (r_state == S_RDONE) || (r_state == S_ERR);
  assign errorOUT           = (r_state == S_ERR);
  assign busyOUT            = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_bus_sram_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_sram_target
// Purpose  : Directed self-checking bench for bus_sram_target. A reference
//            memory array tracks writes; read bursts push their expected
//            words to a queue that is popped as the slave delivers beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_sram_target;

  logic        clock = 1'b0;
  logic        n_reset;
  logic [31:0] address_dataIN;
  logic [3:0]  byte_enableIN;
  logic [7:0]  burst_sizeIN;
  logic        read_n_writeIN;
  logic        begin_transactionIN;
  logic        end_transactionIN;
  logic        data_validIN;
  logic        busyIN;
  logic [31:0] address_dataOUT;
  logic        data_validOUT;
  logic        end_transactionOUT;
  logic        busyOUT;
  logic        errorOUT;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model [0:511];
  logic [31:0] wdata [0:255];
  logic [31:0] exp_q [$];
  logic [31:0] first_word;

  always #5 clock = ~clock;

  bus_sram_target #(
    .BASE_ADDRESS (32'h4000_0000),
    .ADDR_WIDTH   (9)
  ) dut (
    .clock               (clock),
    .n_reset             (n_reset),
    .address_dataIN      (address_dataIN),
    .byte_enableIN       (byte_enableIN),
    .burst_sizeIN        (burst_sizeIN),
    .read_n_writeIN      (read_n_writeIN),
    .begin_transactionIN (begin_transactionIN),
    .end_transactionIN   (end_transactionIN),
    .data_validIN        (data_validIN),
    .busyIN              (busyIN),
    .address_dataOUT     (address_dataOUT),
    .data_validOUT       (data_validOUT),
    .end_transactionOUT  (end_transactionOUT),
    .busyOUT             (busyOUT),
    .errorOUT            (errorOUT)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  // Outputs are sampled and inputs changed on the falling edge.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_data"}, address_dataOUT, 32'd0);
    check({tag, "_ctl"}, {28'd0, data_validOUT, end_transactionOUT, busyOUT, errorOUT}, 32'd0);
  endtask

  task automatic drive_begin(input logic [31:0] addr, input int burst,
                             input logic [3:0] be, input logic rnw);
    begin_transactionIN = 1'b1;
    address_dataIN      = addr;
    burst_sizeIN        = burst[7:0];
    byte_enableIN       = be;
    read_n_writeIN      = rnw;
    end_transactionIN   = 1'b0;
    data_validIN        = 1'b0;
    busyIN              = 1'b0;
  endtask

  // Write nsent beats from wdata[]; end_transactionIN rides on the last beat.
  task automatic wr_burst(input logic [31:0] addr, input int burst,
                          input logic [3:0] be, input int nsent);
    int w;
    w = int'(addr[10:2]);
    tick();
    drive_begin(addr, burst, be, 1'b0);
    for (int i = 0; i < nsent; i++) begin
      tick();
      begin_transactionIN = 1'b0;
      if (i == 0) check("wr_busy", {31'd0, busyOUT}, 32'd0);
      data_validIN      = 1'b1;
      address_dataIN    = wdata[i];
      end_transactionIN = (i == nsent - 1);
      if (i <= burst) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model[(w + i) % 512][8*b +: 8] = wdata[i][8*b +: 8];
        end
      end
    end
    tick();
    check("wr_no_eot", {31'd0, end_transactionOUT}, 32'd0);
    data_validIN      = 1'b0;
    end_transactionIN = 1'b0;
    address_dataIN    = 32'd0;
  endtask

  task automatic rd_burst(input string tag, input logic [31:0] addr, input int burst,
                          input int busy_beat, input int busy_cycles);
    int w;
    int beat;
    int held;
    int nvalid;
    int budget;
    bit first;
    w = int'(addr[10:2]);
    exp_q.delete();
    for (int i = 0; i <= burst; i++) exp_q.push_back(model[(w + i) % 512]);
    tick();
    drive_begin(addr, burst, 4'hF, 1'b1);
    tick();
    begin_transactionIN = 1'b0;
    address_dataIN      = 32'd0;
    check({tag, "_fetch"}, {31'd0, data_validOUT}, 32'd0);
    beat = 0; held = 0; nvalid = 0; budget = 600; first = 1'b1;
    while (exp_q.size() > 0 && budget > 0) begin
      tick();
      budget--;
      if (first) begin
        check({tag, "_lat"}, {31'd0, data_validOUT}, 32'd1);
        first_word = address_dataOUT;
        first = 1'b0;
      end
      if (data_validOUT) begin
        nvalid++;
        check({tag, "_data"}, address_dataOUT, exp_q[0]);
        if (beat == busy_beat && held < busy_cycles) begin
          busyIN = 1'b1;
          held++;
        end else begin
          busyIN = 1'b0;
          void'(exp_q.pop_front());
          beat++;
        end
      end else begin
        check({tag, "_gap"}, {31'd0, data_validOUT}, 32'd1);
        break;
      end
    end
    check({tag, "_left"}, exp_q.size(), 32'd0);
    tick();
    busyIN = 1'b0;
    check({tag, "_eot"}, {31'd0, end_transactionOUT}, 32'd1);
    check({tag, "_eot_dv"}, {30'd0, data_validOUT, errorOUT}, 32'd0);
    tick();
    check({tag, "_eot_1cyc"}, {31'd0, end_transactionOUT}, 32'd0);
    check({tag, "_nvalid"}, nvalid, burst + 1 + busy_cycles);
  endtask

  initial begin
    n_reset             = 1'b0;
    address_dataIN      = 32'd0;
    byte_enableIN       = 4'd0;
    burst_sizeIN        = 8'd0;
    read_n_writeIN      = 1'b0;
    begin_transactionIN = 1'b0;
    end_transactionIN   = 1'b0;
    data_validIN        = 1'b0;
    busyIN              = 1'b0;
    for (int i = 0; i < 512; i++) model[i] = 32'd0;

    // Reset state
    tick();
    tick();
    check_quiet("reset");
    n_reset = 1'b1;

    // Write then read back, 4-word burst at 0x4000_0010
    for (int i = 0; i < 4; i++) wdata[i] = (i + 1) * 32'h1111_1111;
    wr_burst(32'h4000_0010, 3, 4'hF, 4);
    rd_burst("wr_rd", 32'h4000_0010, 3, 99, 0);
    check("wr_rd_word0", first_word, 32'h1111_1111);

    // Partial byte enables
    wdata[0] = 32'hFFFF_FFFF;
    wr_burst(32'h4000_0000, 0, 4'hF, 1);
    wdata[0] = 32'h1234_5678;
    wr_burst(32'h4000_0000, 0, 4'b0101, 1);
    rd_burst("pbe", 32'h4000_0000, 0, 99, 0);
    check("pbe_value", first_word, 32'hFF34_FF78);

    // Read busy stall: second beat held for 2 extra cycles
    rd_burst("stall", 32'h4000_0010, 2, 1, 2);

    // Beats beyond the burst length are ignored
    wdata[0] = 32'h8888_8888;
    wdata[1] = 32'h9999_9999;
    wr_burst(32'h4000_0020, 1, 4'hF, 2);
    wdata[0] = 32'h0000_AAAA;
    wdata[1] = 32'h0000_BBBB;
    wr_burst(32'h4000_0020, 0, 4'hF, 2);
    rd_burst("extra", 32'h4000_0020, 1, 99, 0);
    check("extra_word0", first_word, 32'h0000_AAAA);

    // Out-of-window burst; last word written first so it can be re-read
    wdata[0] = 32'hA5A5_0001;
    wr_burst(32'h4000_07FC, 0, 4'hF, 1);
    tick();
    drive_begin(32'h4000_07FC, 1, 4'hF, 1'b0);
    tick();
    begin_transactionIN = 1'b0;
    data_validIN        = 1'b1;
    address_dataIN      = 32'hDEAD_BEEF;
    check("err_flag", {30'd0, errorOUT, end_transactionOUT}, 32'd3);
    check("err_no_dv", {31'd0, data_validOUT}, 32'd0);
    tick();
    data_validIN   = 1'b0;
    address_dataIN = 32'd0;
    check("err_1cyc", {30'd0, errorOUT, end_transactionOUT}, 32'd0);
    rd_burst("err_mem", 32'h4000_07FC, 0, 99, 0);
    check("err_mem_word", first_word, 32'hA5A5_0001);

    // Unselected read and write get no response
    tick();
    drive_begin(32'h5000_0000, 0, 4'hF, 1'b1);
    tick();
    begin_transactionIN = 1'b0;
    address_dataIN      = 32'd0;
    for (int i = 0; i < 3; i++) begin
      check_quiet("unsel_rd");
      tick();
    end
    drive_begin(32'h5000_0000, 0, 4'hF, 1'b0);
    tick();
    begin_transactionIN = 1'b0;
    data_validIN        = 1'b1;
    end_transactionIN   = 1'b1;
    address_dataIN      = 32'hDEAD_BEEF;
    check_quiet("unsel_wr");
    tick();
    data_validIN      = 1'b0;
    end_transactionIN = 1'b0;
    address_dataIN    = 32'd0;
    rd_burst("unsel_after", 32'h4000_0000, 0, 99, 0);
    check("unsel_word0", first_word, 32'hFF34_FF78);

    // Reset during beat 2 of a 4-beat read
    for (int i = 0; i < 4; i++) wdata[i] = 32'hC0DE_0000 + i;
    wr_burst(32'h4000_0100, 3, 4'hF, 4);
    tick();
    drive_begin(32'h4000_0100, 3, 4'hF, 1'b1);
    tick();
    begin_transactionIN = 1'b0;
    address_dataIN      = 32'd0;
    tick();
    check("rst_beat1", address_dataOUT, model[64]);
    tick();
    check("rst_beat2", address_dataOUT, model[65]);
    #1;
    n_reset = 1'b0;
    #1;
    check_quiet("rst_immediate");
    tick();
    tick();
    n_reset = 1'b1;
    tick();
    check_quiet("rst_after");
    tick();
    check_quiet("rst_no_beats");
    rd_burst("rst_mem", 32'h4000_0100, 3, 99, 0);
    check("rst_mem_word0", first_word, 32'hC0DE_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
